// File: rtl/alu_req_sequencer.sv
// Two-port request sequencer that lets two masters share one registered-output 8-bit ALU.
// Define ALU_SEQ_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module alu_req_sequencer #(
  parameter logic [3:0] IDLE_OP = 4'b1111
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [3:0]  req0_op,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [3:0]  req1_op,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [7:0]  rsp_result,
  output logic [15:0] rsp_product,
  output logic        rsp_of,
  output logic        rsp_zero,
  output logic        rsp_slt,
  output logic        rsp_err,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [7:0]  alu_result,
  input  logic [15:0] alu_product,
  input  logic        alu_of,
  input  logic        alu_zero,
  input  logic        alu_slt
);

  // state | meaning
  // IDLE  | ALU parked on IDLE_OP, arbiter may grant one port
  // EXEC  | operands on the ALU, ALU registers its result at this edge
  // CAPT  | operands still held (flags use live inputs), response captured at this edge
  // RESP  | response presented until rsp_ready
  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t     state;
  logic       id_q;
  logic       err_q;
  logic       grant_id;
  logic       accept_en;
  logic       accept;
  logic [3:0] sel_op;
  logic [7:0] sel_a;
  logic [7:0] sel_b;

`ifdef ALU_SEQ_RR_EN
  logic rr_ptr;
  assign grant_id = (req0_valid && req1_valid) ? rr_ptr : req1_valid;
`else
  assign grant_id = !req0_valid;
`endif

  assign accept_en  = (state == IDLE) && !rst;
  assign req0_ready = accept_en && req0_valid && !grant_id;
  assign req1_ready = accept_en && req1_valid && grant_id;
  assign accept     = req0_ready || req1_ready;

  assign sel_op = grant_id ? req1_op : req0_op;
  assign sel_a  = grant_id ? req1_a  : req0_a;
  assign sel_b  = grant_id ? req1_b  : req0_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_result  <= 8'h00;
      rsp_product <= 16'h0000;
      rsp_of      <= 1'b0;
      rsp_zero    <= 1'b0;
      rsp_slt     <= 1'b0;
      rsp_err     <= 1'b0;
      alu_op      <= IDLE_OP;
      alu_a       <= 8'h00;
      alu_b       <= 8'h00;
      id_q        <= 1'b0;
      err_q       <= 1'b0;
`ifdef ALU_SEQ_RR_EN
      rr_ptr      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_op <= sel_op;
            alu_a  <= sel_a;
            alu_b  <= sel_b;
            id_q   <= grant_id;
            err_q  <= (sel_op > 4'b1011);
            state  <= EXEC;
`ifdef ALU_SEQ_RR_EN
            rr_ptr <= !grant_id;
`endif
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          rsp_valid   <= 1'b1;
          rsp_id      <= id_q;
          rsp_result  <= alu_result;
          rsp_product <= alu_product;
          rsp_of      <= alu_of;
          rsp_zero    <= alu_zero;
          rsp_slt     <= alu_slt;
          rsp_err     <= err_q;
          alu_op      <= IDLE_OP;
          alu_a       <= 8'h00;
          alu_b       <= 8'h00;
          state       <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_req_sequencer.md
# alu_req_sequencer

Two-port request sequencer for the 8-bit clocked ALU, so that two independent masters can share the single ALU instance. It accepts one operation at a time through a valid/ready handshake and arbitrates when both ports request. It drives the ALU operand and opcode inputs, holds them stable across the ALU's registered-output latency, and samples the result, product and flags. It returns them on a single response channel tagged with the requester id.

## Interface
Parameters:
- IDLE_OP, 4'b1111 — opcode driven to the ALU when no operation is in flight (ALU default branch: result/product zero).

Ports:
- clk  in  1  rising-edge clock, shared with the ALU.
- rst  in  1  synchronous, active-high reset.
- req0_valid / req1_valid  in  1  requester 0/1 has an operation.
- req0_ready / req1_ready  out  1  accept strobe; the handshake completes when valid&ready.
- req0_op / req1_op  in  4  ALU opcode (0000..1011 legal).
- req0_a, req0_b / req1_a, req1_b  in  8  operands.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  originating port.
- rsp_result  out  8  sampled ALU result.
- rsp_product  out  16  sampled ALU product.
- rsp_of, rsp_zero, rsp_slt  out  1  sampled ALU flags.
- rsp_err  out  1  opcode was 1100..1111.
- alu_op  out  4  to ALU Op.
- alu_a, alu_b  out  8  to ALU a/b.
- alu_result  in  8  from ALU result.
- alu_product  in  16  from ALU product.
- alu_of, alu_zero, alu_slt  in  1  from ALU flags.

## Operation
- FSM states are IDLE, EXEC, CAPT and RESP.
- IDLE:
  - Drive alu_op=IDLE_OP, alu_a=alu_b=0.
  - If any reqN_valid, the arbiter picks a winner; only that port's ready=1 (combinational, IDLE only).
  - On accept, latch op/a/b/id into holding registers and set err_q = (op > 4'b1011). Go to EXEC.
- EXEC: drive alu_op/a/b from the holding registers; the ALU registers its result at this cycle's edge. Go to CAPT.
- CAPT:
  - Keep driving the same op/a/b. This is mandatory because the ALU's OF, and hence zero/slt, are derived partly from its live inputs.
  - At the edge, capture alu_result, alu_product and the flags into the rsp_* registers, plus rsp_id and rsp_err. Go to RESP.
- RESP:
  - rsp_valid=1 and the rsp_* outputs are held stable.
  - alu_op returns to IDLE_OP.
  - On rsp_ready, go to IDLE.
- Illegal opcodes are still issued. The ALU returns 0/0; the flags are passed through as sampled, and rsp_err=1.
- Requests are never queued. A port not granted keeps valid high and is served later.
- Reset values:
  - state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_product=0, rsp_of/zero/slt/err=0.
  - req0_ready=req1_ready=0 during rst.
  - alu_op=IDLE_OP, alu_a=alu_b=0.
  - The RR pointer favours port 0.
- Reset mid-operation (any state) abandons the operation with no response. The accepted request is lost; the requester must reissue it.

## Timing
- Accept at cycle T (IDLE) leads to EXEC at T+1, CAPT at T+2 and rsp_valid=1 at T+3.
- If rsp_ready=1 at T+3, the block is in IDLE at T+4 and the next accept can occur at T+4. Peak throughput is one operation per 4 cycles.
- rsp_ready low holds RESP indefinitely. Both req*_ready stay 0, and the ALU sees IDLE_OP.
- rsp_ready asserted while not in RESP is ignored.
- Simultaneous req0_valid and req1_valid in IDLE are resolved by the arbiter (see Configuration). A single valid port always wins immediately.
- Requester inputs are sampled only on the accept cycle; later changes have no effect on the operation in flight.

## Configuration
- Macro: ALU_SEQ_RR_EN.
- Defined: round-robin arbitration.
  - A 1-bit pointer marks the preferred port; after each grant it moves to the other port.
  - The pointer resets to prefer port 0.
- Undefined: fixed priority, port 0 always wins when both are valid. There is no pointer register, and port 1 can starve.

## Test plan
- Port 0 add (op 1001, a=0x05, b=0x03), accepted at T → rsp_valid at T+3 with result=0x08, product=0x0000, of=0, zero=0, rsp_id=0, err=0.
- Port 1 sub (op 1010, a=0x03, b=0x05) → result=0xFE, slt=1, of=0, rsp_id=1.
- Both ports valid continuously, each issuing two adds, rsp_ready=1:
  - With ALU_SEQ_RR_EN the response ids are 0,1,0,1.
  - Without it they are 0,0 (then 1,1 once port 0 drops valid).
- Multiply (op 1011, a=0x10, b=0x10) → product=0x0100, result=0x00. Illegal op 1110 → result=0, product=0, err=1.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_* stable, req*_ready=0 throughout, alu_op=IDLE_OP. Release → IDLE next cycle.
- Assert rst during EXEC → next cycle state IDLE, rsp_valid=0, all outputs at reset values, and no response is ever produced for the aborted operation.
